// File: rtl/rx_fifo_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_fifo_buf : multi-frame CAN receive buffer (tail write/commit, head read/release).
// Optional macro RX_FIFO_INIT_EN resets every storage word to all-ones.  Rev 1.0
// ---------------------------------------------------------------------------
module rx_fifo_buf #(
  parameter int DW         = 8,
  parameter int SLOT_BYTES = 13,
  parameter int SLOTS      = 4,
  parameter int AW         = 4,
  parameter int PW         = 2
) (
  input  logic          clk,
  input  logic          rs,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  input  logic          b_wrn,
  input  logic          b_commit,
  input  logic          b_abort,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_dout,
  input  logic          a_rel,
  input  logic          clr_ovr,
  output logic [PW:0]   frm_cnt,
  output logic          empty,
  output logic          full,
  output logic          overrun
);

  localparam logic [AW:0]   NBYTES = (AW+1)'(SLOT_BYTES);
  localparam logic [PW:0]   NSLOTS = (PW+1)'(SLOTS);
  localparam logic [PW-1:0] LAST   = PW'(SLOTS-1);

  logic [DW-1:0] mem [SLOTS][SLOT_BYTES];
  logic [PW-1:0] hp, tp;
  logic          wr_addr_ok, rd_addr_ok;
  logic          wr_en, com_req, com_ok, com_rej, rel_ok;
  logic [PW:0]   cnt_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // When full, tail and head share a slot; a tail write is only safe if the
  // head is released in the same cycle.
  always_comb begin
    wr_addr_ok = ({1'b0, b_addr} < NBYTES);
    rd_addr_ok = ({1'b0, a_addr} < NBYTES);
    wr_en      = !b_wrn && wr_addr_ok && (!full || a_rel);
    com_req    = b_commit && !b_abort;
    com_ok     = com_req && (!full || a_rel);
    com_rej    = com_req && full && !a_rel;
    rel_ok     = a_rel && !empty;
    cnt_nxt    = frm_cnt;
    if (com_ok && !rel_ok)
      cnt_nxt = frm_cnt + 1'b1;
    else if (!com_ok && rel_ok)
      cnt_nxt = frm_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      hp      <= '0;
      tp      <= '0;
      frm_cnt <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (com_ok)
        tp <= ptr_inc(tp);
      if (rel_ok)
        hp <= ptr_inc(hp);
      frm_cnt <= cnt_nxt;
      empty   <= (cnt_nxt == '0);
      full    <= (cnt_nxt == NSLOTS);
      if (com_rej)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end

`ifdef RX_FIFO_INIT_EN
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      for (int s = 0; s < SLOTS; s++)
        for (int b = 0; b < SLOT_BYTES; b++)
          mem[s][b] <= '1;
    end else if (wr_en) begin
      mem[tp][b_addr] <= b_din;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[tp][b_addr] <= b_din;
  end
`endif

  always_comb begin
    a_dout = '0;
    if (!empty && rd_addr_ok)
      a_dout = mem[hp][a_addr];
  end

endmodule
`default_nettype wire

// File: doc/rx_fifo_buf.md
# rx_fifo_buf

Parametrised multi-frame receive buffer for the Basic CAN controller. The receive engine writes one frame's bytes by index into the tail slot, then commits it. The host interface reads bytes by index from the head slot, then releases it. The buffer holds up to SLOTS frames of SLOT_BYTES bytes each. It tracks fill level and flags overrun when a frame is committed with no free slot.

## Interface
- DW, 8, data width in bits
- SLOT_BYTES, 13, bytes per frame slot (descriptor, ID, 8 data bytes)
- SLOTS, 4, number of frame slots (≥2, any integer)
- AW, 4, byte-index width; must satisfy 2^AW ≥ SLOT_BYTES
- PW, 2, slot-pointer width; must satisfy 2^PW ≥ SLOTS

Ports:
- clk  in  1  clock, all state on rising edge
- rs  in  1  asynchronous reset, active high
- b_addr  in  AW  byte index within tail slot
- b_din  in  DW  write data
- b_wrn  in  1  byte write strobe, active low
- b_commit  in  1  commit tail slot as a frame, single-cycle pulse
- b_abort  in  1  discard tail slot contents, single-cycle pulse
- a_addr  in  AW  byte index within head slot
- a_dout  out  DW  read data, combinational
- a_rel  in  1  release head slot, single-cycle pulse
- clr_ovr  in  1  clear overrun flag
- frm_cnt  out  PW+1  number of committed frames held
- empty  out  1  frm_cnt == 0
- full  out  1  frm_cnt == SLOTS
- overrun  out  1  sticky overrun flag

## Operation
- State: storage of SLOTS×SLOT_BYTES words; head pointer `hp`, tail pointer `tp` (PW bits, wrap SLOTS-1→0); `frm_cnt`; `overrun`.
- Reset values: hp=0, tp=0, frm_cnt=0, empty=1, full=0, overrun=0. a_dout=0 while empty.
- Write: on b_wrn=0 with b_addr<SLOT_BYTES and full=0, store b_din at [tp][b_addr].
- A write with b_addr≥SLOT_BYTES is ignored.
- A write while full=0 but with a release in the same cycle proceeds normally.
- A write while full=1 with no release in the same cycle is dropped.
- Commit: b_commit=1 and (full=0 or a_rel=1) → tp advances and frm_cnt increments.
- Commit with full=1 and a_rel=0: frame discarded, tp unchanged, overrun←1.
- A write and a commit in the same cycle: the byte is written before the commit, so it belongs to the committed frame.
- Abort: no pointer change. Tail contents are left stale and are overwritten by the next frame. b_abort has priority over a simultaneous b_commit.
- Release: a_rel=1 with empty=0 → hp advances and frm_cnt decrements. A release while empty is ignored.
- Commit and release in the same cycle: both pointers advance and frm_cnt is unchanged.
- Read: a_dout = [hp][a_addr] when empty=0 and a_addr<SLOT_BYTES, else 0.
- overrun: set by a rejected commit, cleared by clr_ovr. A rejected commit and clr_ovr in the same cycle leave overrun=1 (set wins).

## Timing
- Write, commit, release and abort take effect at the rising edge where they are sampled.
- frm_cnt, empty, full and overrun are registered and update 1 cycle after the strobe.
- a_dout has zero latency from a_addr. It reflects the new head slot in the cycle after a release.
- A committed frame is readable in the cycle after the commit edge.
- Asserting rs mid-frame discards all frames and any partial tail immediately (asynchronous reset).

## Configuration
- RX_FIFO_INIT_EN defined: every storage word resets to all-ones (8'hff at DW=8). A slot read before it is ever written therefore returns all-ones.
- RX_FIFO_INIT_EN undefined: storage has no reset, so it can map to RAM. Only pointers, count and flags reset. Stored contents are undefined until written.

## Test plan
- Reset, then write bytes 0..12 with 8'h10..8'h1C and commit → next cycle empty=0 and frm_cnt=1; a_addr 0..12 reads 8'h10..8'h1C; a_addr=13 reads 8'h00.
- Commit 4 frames (SLOTS=4), then commit a fifth → full=1, overrun=1, frm_cnt=4; release 4 times and read → the first four frames come out in order.
- With full=1, pulse b_commit and a_rel together → frm_cnt stays 4, overrun stays 0, and the new frame is readable last.
- Write byte 0=8'hAA then abort; write byte 0=8'h55 and commit → head byte 0 reads 8'h55.
- Drive tp and hp across the wrap for 10 frames (interleaved commit/release) → data order is preserved and frm_cnt never exceeds 4.
- With RX_FIFO_INIT_EN defined, assert rs mid-write, then commit without writing → all bytes of the frame read 8'hFF.
